psum_drain: RTL and testbench
=============================

Name: psum_drain

Overview:
- Drains partial-sum beats produced by the systolic array and converts them into addressed write transactions toward output memory.
- It is the output-side counterpart of the feeder. The feeder turns memory words into array activations; this block turns array psum beats back into memory words with linear addresses.
- It buffers the beats because the array cannot be stalled. It performs lane reordering and optional ReLU, counts words against the configured output volume, and reports done, overflow and excess errors.

Parameters:
- STREAM_WIDTH, 4: psum lanes per beat (`stream_width).
- C_WIDTH, 32: bits per psum lane (`C_WIDTH).
- ADDR_WIDTH, 16: output address width.
- FIFO_DEPTH, 8: beat buffer depth; must be a power of 2, minimum 2.
- REVERSE_LANES, 1: 1 = output lane v takes input lane STREAM_WIDTH-1-v.
- RELU, 0: 1 = negative lanes (signed) are written as 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse; latches the config inputs and arms the block.
- o_dimension  in  ADDR_WIDTH  output rows, which equal output cols.
- chans_per_mem  in  ADDR_WIDTH  words per output pixel (channels/STREAM_WIDTH).
- base_addr  in  ADDR_WIDTH  first write address.
- psum_in  in  STREAM_WIDTH*C_WIDTH  psum beat from the array.
- psum_valid  in  1  beat qualifier. There is no backpressure on this input.
- wr_data  out  STREAM_WIDTH*C_WIDTH  write data.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the last word is accepted.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.
- excess  out  1  sticky: a beat arrived after the word count reached total.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied.
  - Counters go to 0.
  - wr_valid, busy, done, overflow and excess are 0; wr_data and wr_addr are 0.
- FSM states: IDLE, CALC, DRAIN, DONE.
- IDLE:
  - psum_valid is ignored.
  - On start: latch the config inputs, clear overflow and excess, go to CALC.
- CALC (1 cycle):
  - Compute total = o_dimension*o_dimension*chans_per_mem, truncated to ADDR_WIDTH+1 bits.
  - Clear the accepted-beat count and the write count.
  - If total==0, go to DONE; otherwise go to DRAIN.
  - psum beats arriving during CALC are accepted into the FIFO.
- DRAIN, push side:
  - A beat is pushed when psum_valid=1 and accepted < total.
  - Lanes are reordered per REVERSE_LANES and ReLU is applied before the FIFO write.
- DRAIN, overflow:
  - If the FIFO is full and no pop occurs in the same cycle, the beat is dropped and overflow is set.
  - A dropped beat does not increment the accepted count.
- DRAIN, excess:
  - If psum_valid=1 while accepted==total, the beat is dropped and excess is set.
- DRAIN, pop side:
  - wr_valid = FIFO not empty.
  - wr_data = FIFO head.
  - wr_addr = base_addr + written, wrapping modulo 2^ADDR_WIDTH.
  - A write completes on wr_valid & wr_ready; the head is then popped and written is incremented.
  - wr_data and wr_addr hold stable while wr_valid=1 and wr_ready=0.
- Latency: a beat pushed in cycle n into an empty FIFO gives wr_valid=1 in cycle n+1. There is no combinational fall-through.
- Push and pop in the same cycle:
  - Both are always legal, including when the FIFO is full; the occupancy is unchanged.
  - When the FIFO is empty, the pop cannot occur in that cycle.
- Completion: when the write that makes written==total completes, go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Go to IDLE on the next cycle; busy drops in that IDLE cycle.
- start while busy: ignored.
- Reset mid-operation: immediate abort. Buffered beats are lost and there is no done pulse.
- Sticky flags: overflow and excess stay set through DONE and IDLE until the next start or reset.
- Arithmetic: ReLU tests the lane MSB. Address wrap is silent.

Decomposition:
- Shared package/defs: STREAM_WIDTH/C_WIDTH defaults via `stream_width/`C_WIDTH, C_STREAM_WIDTH, and the FSM state enum psum_drain_state_t.
- One sub-module, sync_fifo:
  - Parameterised on width and depth.
  - Registered head output.
  - full/empty flags and a count output.
  - Simultaneous push/pop when full is supported.

Test Plan:
1. Basic drain: o_dimension=2, chans_per_mem=1, base_addr=0x100, wr_ready=1, four consecutive beats 0x..01 to 0x..04 -> writes to addresses 0x100-0x103, in order, lanes reversed. done pulses one cycle after the 4th write is accepted. overflow=0, excess=0.
2. Backpressure:
   - Stimulus: total=16, FIFO_DEPTH=8, wr_ready held at 0 for 8 cycles while 8 beats arrive, then the 9th beat arrives with wr_ready still 0.
   - Response: overflow=1. Only 8 words are written. done does not pulse until 16 accepted beats have been written.
3. Throttled ready: 50% random wr_ready, beats spaced 1 in 3 cycles, total=18 -> all 18 words are written in order. wr_data and wr_addr are stable during stalls.
4. Excess and ReLU:
   - Stimulus: RELU=1, total=4, a 5th beat arrives, lane value 0xFFFFFFF0.
   - Response: excess=1. The lane is written as 0x00000000.
5. Boundary: o_dimension=0 start -> done pulses 2 cycles after start with no writes. A second start while busy is ignored.
6. Reset abort: rst=0 asserted mid-drain with 3 words buffered -> wr_valid, busy and done are 0 immediately (asynchronously). A new start then drains a fresh total from base_addr.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// Shared defaults and FSM state type for the psum drain path.
// Lane count and lane width can be overridden from the build via the macros below.
`ifndef STREAM_WIDTH
`define STREAM_WIDTH 4
`endif
`ifndef C_WIDTH
`define C_WIDTH 32
`endif

package psum_drain_pkg;

    localparam int PD_STREAM_WIDTH = `STREAM_WIDTH;
    localparam int PD_C_WIDTH      = `C_WIDTH;
    localparam int C_STREAM_WIDTH  = PD_STREAM_WIDTH * PD_C_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } psum_drain_state_t;

endpackage

// File: rtl/psum_drain_sync_fifo.sv
// Beat buffer with a registered head word, full/empty flags and an occupancy count.
// Push is accepted while full as long as a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            // Head tracks the oldest entry; an incoming word goes straight to head only when it becomes the sole entry.
            if (do_pop) begin
                if (count_reg == CW'(1)) begin
                    if (do_push) begin
                        head_reg <= din;
                    end
                end else begin
                    head_reg <= mem[rd_ptr_reg + AW'(1)];
                end
            end else if (do_push && (count_reg == '0)) begin
                head_reg <= din;
            end
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/psum_drain.sv
// Turns free-running psum beats from the array into linearly addressed memory writes,
// with lane reordering, optional ReLU, volume counting and sticky drop flags.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int STREAM_WIDTH  = PD_STREAM_WIDTH,
    parameter int C_WIDTH       = PD_C_WIDTH,
    parameter int ADDR_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter bit REVERSE_LANES = 1'b1,
    parameter bit RELU          = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             o_dimension,
    input  logic [ADDR_WIDTH-1:0]             chans_per_mem,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [STREAM_WIDTH*C_WIDTH-1:0]   psum_in,
    input  logic                              psum_valid,
    output logic [STREAM_WIDTH*C_WIDTH-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic                              wr_valid,
    input  logic                              wr_ready,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic                              excess
);

    localparam int W   = STREAM_WIDTH * C_WIDTH;
    localparam int CW  = ADDR_WIDTH + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    psum_drain_state_t       state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   o_dim_reg, o_dim_next;
    logic [ADDR_WIDTH-1:0]   chans_reg, chans_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [CW-1:0]           total_reg, total_next;
    logic [CW-1:0]           accepted_reg, accepted_next;
    logic [CW-1:0]           written_reg, written_next;
    logic                    overflow_reg, overflow_next;
    logic                    excess_reg, excess_next;

    logic [3*ADDR_WIDTH-1:0] product;
    logic [CW-1:0]           total_calc;
    logic [CW-1:0]           total_cur;
    logic [CW-1:0]           accepted_cur;
    logic                    beat_live;
    logic [W-1:0]            beat_fmt;
    logic [W-1:0]            fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FCW-1:0]          fifo_count;
    logic                    push;
    logic                    pop;

    genvar gi;
    generate
        for (gi = 0; gi < STREAM_WIDTH; gi++) begin : g_lane
            localparam int SRC = REVERSE_LANES ? (STREAM_WIDTH - 1 - gi) : gi;
            logic [C_WIDTH-1:0] lane;
            assign lane = psum_in[SRC*C_WIDTH +: C_WIDTH];
            assign beat_fmt[gi*C_WIDTH +: C_WIDTH] = (RELU && lane[C_WIDTH-1]) ? '0 : lane;
        end
    endgenerate

    assign product    = o_dim_reg * o_dim_reg * chans_reg;
    assign total_calc = product[CW-1:0];

    // During CALC the registered total and count are not valid yet, so use the fresh values.
    assign total_cur    = (state_reg == ST_CALC) ? total_calc : total_reg;
    assign accepted_cur = (state_reg == ST_CALC) ? '0 : accepted_reg;
    assign beat_live    = psum_valid && ((state_reg == ST_CALC) || (state_reg == ST_DRAIN));
    assign pop          = (state_reg == ST_DRAIN) && !fifo_empty && wr_ready;

    always_comb begin
        state_next    = state_reg;
        o_dim_next    = o_dim_reg;
        chans_next    = chans_reg;
        base_next     = base_reg;
        total_next    = total_reg;
        accepted_next = accepted_reg;
        written_next  = written_reg;
        overflow_next = overflow_reg;
        excess_next   = excess_reg;
        push          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    o_dim_next    = o_dimension;
                    chans_next    = chans_per_mem;
                    base_next     = base_addr;
                    overflow_next = 1'b0;
                    excess_next   = 1'b0;
                    state_next    = ST_CALC;
                end
            end
            ST_CALC: begin
                total_next    = total_calc;
                accepted_next = '0;
                written_next  = '0;
                state_next    = (total_calc == '0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && ((written_reg + CW'(1)) == total_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (beat_live) begin
            if (accepted_cur == total_cur) begin
                if (state_reg == ST_DRAIN) begin
                    excess_next = 1'b1;
                end
            end else if (fifo_full && !pop) begin
                overflow_next = 1'b1;
            end else begin
                push          = 1'b1;
                accepted_next = accepted_cur + CW'(1);
            end
        end

        if (pop) begin
            written_next = written_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            o_dim_reg    <= '0;
            chans_reg    <= '0;
            base_reg     <= '0;
            total_reg    <= '0;
            accepted_reg <= '0;
            written_reg  <= '0;
            overflow_reg <= 1'b0;
            excess_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            o_dim_reg    <= o_dim_next;
            chans_reg    <= chans_next;
            base_reg     <= base_next;
            total_reg    <= total_next;
            accepted_reg <= accepted_next;
            written_reg  <= written_next;
            overflow_reg <= overflow_next;
            excess_reg   <= excess_next;
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (beat_fmt),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid = (state_reg == ST_DRAIN) && (fifo_count != '0);
    assign wr_data  = fifo_head;
    assign wr_addr  = base_reg + written_reg[ADDR_WIDTH-1:0];
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign overflow = overflow_reg;
    assign excess   = excess_reg;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: each task drives one scenario and checks against hand-derived values.
`timescale 1ns/1ps
module tb_psum_drain;

    localparam int SW  = 4;
    localparam int CWD = 32;
    localparam int AW  = 16;
    localparam int W   = SW * CWD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] o_dimension = '0;
    logic [AW-1:0] chans_per_mem = '0;
    logic [AW-1:0] base_addr = '0;
    logic [W-1:0]  psum_in = '0;
    logic          psum_valid = 1'b0;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          excess;

    always #5 clk = ~clk;

    psum_drain #(
        .STREAM_WIDTH  (SW),
        .C_WIDTH       (CWD),
        .ADDR_WIDTH    (AW),
        .FIFO_DEPTH    (8),
        .REVERSE_LANES (1'b1),
        .RELU          (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .o_dimension   (o_dimension),
        .chans_per_mem (chans_per_mem),
        .base_addr     (base_addr),
        .psum_in       (psum_in),
        .psum_valid    (psum_valid),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .excess        (excess)
    );

    int errors = 0;
    int checks = 0;

    // Write monitor: samples on the falling edge, when inputs and registered outputs are settled.
    logic [AW-1:0] wa_q[$];
    logic [W-1:0]  wd_q[$];
    int            negcyc = 0;
    int            done_count = 0;
    int            done_cyc = -1;
    int            last_wr_cyc = -1;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        negcyc++;
        if (prev_stall && wr_valid) begin
            checks++;
            if (wr_data !== prev_data || wr_addr !== prev_addr) begin
                errors++;
                $display("FAIL stall_hold: addr=%h data=%h, required addr=%h data=%h",
                         wr_addr, wr_data, prev_addr, prev_data);
            end
        end
        prev_stall = wr_valid && !wr_ready;
        prev_data  = wr_data;
        prev_addr  = wr_addr;
        if (wr_valid && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            last_wr_cyc = negcyc;
            $display("write addr=%h data=%h", wr_addr, wr_data);
        end
        if (done) begin
            done_count++;
            done_cyc = negcyc;
        end
    end

    function automatic logic [W-1:0] mk_beat(input int k);
        logic [W-1:0] b;
        for (int i = 0; i < SW; i++) begin
            b[i*CWD +: CWD] = CWD'((k << 8) | i);
        end
        return b;
    endfunction

    // Reference: output lane v = input lane SW-1-v, negative lanes forced to zero.
    function automatic logic [W-1:0] exp_word(input logic [W-1:0] b);
        logic [W-1:0]   w;
        logic [CWD-1:0] lane;
        for (int v = 0; v < SW; v++) begin
            lane = b[(SW-1-v)*CWD +: CWD];
            if (lane[CWD-1]) lane = '0;
            w[v*CWD +: CWD] = lane;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_count  = 0;
        done_cyc    = -1;
        last_wr_cyc = -1;
    endtask

    task automatic do_start(input logic [AW-1:0] odim, input logic [AW-1:0] chans,
                            input logic [AW-1:0] base);
        o_dimension   = odim;
        chans_per_mem = chans;
        base_addr     = base;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (excess !== 1'b0) begin errors++; $display("FAIL reset_excess: got %b want 0", excess); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp1 [4];
        bit to;
        exp1[0] = 128'h00000100_00000101_00000102_00000103;
        exp1[1] = 128'h00000200_00000201_00000202_00000203;
        exp1[2] = 128'h00000300_00000301_00000302_00000303;
        exp1[3] = 128'h00000400_00000401_00000402_00000403;
        clear_mon();
        wr_ready = 1'b1;
        do_start(16'd2, 16'd1, 16'h0100);
        for (int k = 1; k <= 4; k++) begin
            psum_in    = mk_beat(k);
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        wait_idle(30, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d writes want 4", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 4; i++) begin
            checks++;
            if (wa_q[i] !== 16'h0100 + AW'(i) || wd_q[i] !== exp1[i]) begin
                errors++;
                $display("FAIL basic_write%0d: addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 16'h0100 + AW'(i), exp1[i]);
            end
        end
        checks++; if (done_count != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
        checks++; if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL basic_done_timing: done cycle %0d want %0d", done_cyc, last_wr_cyc + 1); end
        checks++; if (overflow !== 1'b0 || excess !== 1'b0) begin errors++; $display("FAIL basic_flags: overflow=%b excess=%b want 0 0", overflow, excess); end
    endtask

    task automatic test_backpressure();
        int seq [16];
        bit to;
        clear_mon();
        wr_ready = 1'b0;
        do_start(16'd4, 16'd1, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            psum_in    = mk_beat(k);
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL bp_no_writes: got %0d want 0", wa_q.size()); end
        wr_ready = 1'b1;
        repeat (12) tick();
        checks++; if (wa_q.size() != 8) begin errors++; $display("FAIL bp_first_drain: got %0d writes want 8", wa_q.size()); end
        checks++; if (done_count != 0 || busy !== 1'b1) begin errors++; $display("FAIL bp_early_done: done_count=%0d busy=%b want 0 1", done_count, busy); end
        for (int k = 10; k <= 17; k++) begin
            psum_in    = mk_beat(k);
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        wait_idle(40, to);
        for (int i = 0; i < 8; i++) seq[i] = i + 1;
        for (int i = 8; i < 16; i++) seq[i] = i + 2;
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: busy still %b want 0", busy); end
        checks++; if (wa_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d writes want 16", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 16; i++) begin
            checks++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_word(mk_beat(seq[i]))) begin
                errors++;
                $display("FAIL bp_write%0d: addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], AW'(i), exp_word(mk_beat(seq[i])));
            end
        end
        checks++; if (done_count != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_throttled();
        int sent = 0;
        int c = 0;
        logic [AW-1:0] ea;
        clear_mon();
        do_start(16'd3, 16'd2, 16'hFFFE);
        while (busy && c < 400) begin
            wr_ready = (((c * 37 + 11) % 8) >= 4);
            if ((c % 3 == 0) && sent < 18) begin
                psum_in    = mk_beat(40 + sent);
                psum_valid = 1'b1;
                sent++;
            end else begin
                psum_valid = 1'b0;
            end
            tick();
            c++;
        end
        psum_valid = 1'b0;
        wr_ready   = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL thr_timeout: busy still %b want 0", busy); end
        checks++; if (wa_q.size() != 18) begin errors++; $display("FAIL thr_count: got %0d writes want 18", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 18; i++) begin
            ea = 16'hFFFE + AW'(i);
            checks++;
            if (wa_q[i] !== ea || wd_q[i] !== exp_word(mk_beat(40 + i))) begin
                errors++;
                $display("FAIL thr_write%0d: addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], ea, exp_word(mk_beat(40 + i)));
            end
        end
        checks++; if (done_count != 1) begin errors++; $display("FAIL thr_done_count: got %0d want 1", done_count); end
        checks++; if (overflow !== 1'b0 || excess !== 1'b0) begin errors++; $display("FAIL thr_flags: overflow=%b excess=%b want 0 0", overflow, excess); end
    endtask

    task automatic test_excess_relu();
        logic [W-1:0] bin [5];
        logic [W-1:0] bexp [4];
        bit to;
        bin[0]  = 128'h00000007_00000006_00000005_FFFFFFF0;
        bin[1]  = 128'h80000000_00000001_00000002_00000003;
        bin[2]  = 128'hFFFFFFFF_7FFFFFFF_00000000_00000011;
        bin[3]  = 128'h00000504_00000503_00000502_00000501;
        bin[4]  = 128'h000000AA_000000AB_000000AC_000000AD;
        bexp[0] = 128'h00000000_00000005_00000006_00000007;
        bexp[1] = 128'h00000003_00000002_00000001_00000000;
        bexp[2] = 128'h00000011_00000000_7FFFFFFF_00000000;
        bexp[3] = 128'h00000501_00000502_00000503_00000504;
        clear_mon();
        wr_ready = 1'b1;
        do_start(16'd2, 16'd1, 16'h0300);
        for (int k = 0; k < 5; k++) begin
            psum_in    = bin[k];
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        wait_idle(20, to);
        checks++; if (to) begin errors++; $display("FAIL exr_timeout: busy still %b want 0", busy); end
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL exr_count: got %0d writes want 4", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 4; i++) begin
            checks++;
            if (wa_q[i] !== 16'h0300 + AW'(i) || wd_q[i] !== bexp[i]) begin
                errors++;
                $display("FAIL exr_write%0d: addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 16'h0300 + AW'(i), bexp[i]);
            end
        end
        checks++; if (excess !== 1'b1) begin errors++; $display("FAIL exr_excess: got %b want 1", excess); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL exr_overflow: got %b want 0", overflow); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL exr_done_count: got %0d want 1", done_count); end
    endtask

    task automatic test_boundary();
        clear_mon();
        do_start(16'd0, 16'd5, 16'h0010);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL bnd_calc: busy=%b done=%b want 1 0", busy, done); end
        checks++; if (excess !== 1'b0) begin errors++; $display("FAIL bnd_excess_clear: got %b want 0", excess); end
        o_dimension = 16'd2;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bnd_done: got %b want 1", done); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bnd_idle: done=%b busy=%b want 0 0", done, busy); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bnd_restart: busy=%b want 0", busy); end
        checks++; if (wa_q.size() != 0 || done_count != 1) begin errors++; $display("FAIL bnd_no_writes: writes=%0d dones=%0d want 0 1", wa_q.size(), done_count); end
    endtask

    task automatic test_reset_abort();
        bit to;
        clear_mon();
        wr_ready = 1'b0;
        do_start(16'd2, 16'd2, 16'h0040);
        for (int k = 1; k <= 3; k++) begin
            psum_in    = mk_beat(60 + k);
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        tick();
        checks++; if (wr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: wr_valid=%b busy=%b want 1 1", wr_valid, busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_async: wr_valid=%b busy=%b done=%b want 0 0 0", wr_valid, busy, done); end
        tick();
        rst = 1'b1;
        tick();
        clear_mon();
        psum_in    = mk_beat(99);
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        wr_ready   = 1'b1;
        do_start(16'd1, 16'd2, 16'h0200);
        for (int k = 0; k < 2; k++) begin
            psum_in    = mk_beat(70 + k);
            psum_valid = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        wait_idle(20, to);
        checks++; if (to) begin errors++; $display("FAIL abort_timeout: busy still %b want 0", busy); end
        checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL abort_count: got %0d writes want 2", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 2; i++) begin
            checks++;
            if (wa_q[i] !== 16'h0200 + AW'(i) || wd_q[i] !== exp_word(mk_beat(70 + i))) begin
                errors++;
                $display("FAIL abort_write%0d: addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 16'h0200 + AW'(i), exp_word(mk_beat(70 + i)));
            end
        end
        checks++; if (done_count != 1 || overflow !== 1'b0) begin errors++; $display("FAIL abort_done: dones=%0d overflow=%b want 1 0", done_count, overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_throttled();
        test_excess_relu();
        test_boundary();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
